// File: rtl/id_ex_fwd_stage_if.sv
// rtl/id_ex_fwd_stage_if.sv - ID-side and EX-side operand/control bundle of the ID/EX stage
interface id_ex_fwd_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd_dst;
    logic              id_reg_write;
    logic              id_mem_read;

    logic              ex_valid;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd_dst;
    logic              ex_reg_write;
    logic              ex_mem_read;

    // Decode side drives ID fields and observes EX fields.
    modport master (
        output id_valid, id_rs_data, id_rt_data, id_rs, id_rt, id_rd_dst,
               id_reg_write, id_mem_read,
        input  ex_valid, ex_rs_data, ex_rt_data, ex_rs, ex_rt, ex_rd_dst,
               ex_reg_write, ex_mem_read
    );

    // The pipeline register consumes ID fields and produces EX fields.
    modport slave (
        input  id_valid, id_rs_data, id_rt_data, id_rs, id_rt, id_rd_dst,
               id_reg_write, id_mem_read,
        output ex_valid, ex_rs_data, ex_rt_data, ex_rs, ex_rt, ex_rd_dst,
               ex_reg_write, ex_mem_read
    );
endinterface

// File: rtl/id_ex_fwd_stage.sv
// rtl/id_ex_fwd_stage.sv - ID/EX pipeline register with forwarding selects and load-use stall
module id_ex_fwd_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    id_ex_fwd_stage_if.slave  bus,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              load_use_stall,
    output logic [CNT_W-1:0]  stall_cycles
);
    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    logic              ex_valid_q;
    logic [DATA_W-1:0] ex_rs_data_q;
    logic [DATA_W-1:0] ex_rt_data_q;
    logic [REG_AW-1:0] ex_rs_q;
    logic [REG_AW-1:0] ex_rt_q;
    logic [REG_AW-1:0] ex_rd_dst_q;
    logic              ex_reg_write_q;
    logic              ex_mem_read_q;
    logic [CNT_W-1:0]  stall_cycles_q;
    logic              load_use;

    // A load in EX whose destination feeds the instruction now in ID must wait one cycle.
    always_comb begin
        load_use = ex_valid_q && ex_mem_read_q && (ex_rd_dst_q != '0) && bus.id_valid &&
                   ((ex_rd_dst_q == bus.id_rs) || (ex_rd_dst_q == bus.id_rt));
    end

    // Pipeline register: reset > flush > stall > load-use bubble > capture; stall counter alongside.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q     <= 1'b0;
            ex_rs_data_q   <= '0;
            ex_rt_data_q   <= '0;
            ex_rs_q        <= '0;
            ex_rt_q        <= '0;
            ex_rd_dst_q    <= '0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            if (flush || (!stall && load_use)) begin
                ex_valid_q     <= 1'b0;
                ex_reg_write_q <= 1'b0;
                ex_mem_read_q  <= 1'b0;
            end else if (!stall) begin
                ex_valid_q     <= bus.id_valid;
                ex_rs_data_q   <= bus.id_rs_data;
                ex_rt_data_q   <= bus.id_rt_data;
                ex_rs_q        <= bus.id_rs;
                ex_rt_q        <= bus.id_rt;
                ex_rd_dst_q    <= bus.id_rd_dst;
                ex_reg_write_q <= bus.id_reg_write;
                ex_mem_read_q  <= bus.id_mem_read;
            end
            if (load_use && (stall_cycles_q != {CNT_W{1'b1}})) begin
                stall_cycles_q <= stall_cycles_q + 1'b1;
            end
        end
    end

    // Operand selects: the younger EX/MEM result wins over MEM/WB; $0 is never forwarded.
    always_comb begin
        fwd_a_sel = SEL_RF;
        fwd_b_sel = SEL_RF;
        if (ex_valid_q) begin
            if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs_q)) begin
                fwd_a_sel = SEL_MEM;
            end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs_q)) begin
                fwd_a_sel = SEL_WB;
            end
            if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rt_q)) begin
                fwd_b_sel = SEL_MEM;
            end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rt_q)) begin
                fwd_b_sel = SEL_WB;
            end
        end
    end

    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_rs_data   = ex_rs_data_q;
    assign bus.ex_rt_data   = ex_rt_data_q;
    assign bus.ex_rs        = ex_rs_q;
    assign bus.ex_rt        = ex_rt_q;
    assign bus.ex_rd_dst    = ex_rd_dst_q;
    assign bus.ex_reg_write = ex_valid_q & ex_reg_write_q;
    assign bus.ex_mem_read  = ex_valid_q & ex_mem_read_q;
    assign load_use_stall   = load_use;
    assign stall_cycles     = stall_cycles_q;
endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// tb/tb_id_ex_fwd_stage.sv - self-checking bench for id_ex_fwd_stage
module tb_id_ex_fwd_stage;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              stall = 1'b0;
    logic              flush = 1'b0;
    logic              mem_reg_write = 1'b0;
    logic [REG_AW-1:0] mem_rd = '0;
    logic              wb_reg_write = 1'b0;
    logic [REG_AW-1:0] wb_rd = '0;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic              load_use_stall;
    logic [CNT_W-1:0]  stall_cycles;

    int vectors = 0;
    int miscompares = 0;

    id_ex_fwd_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

    id_ex_fwd_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .bus            (bus),
        .mem_reg_write  (mem_reg_write),
        .mem_rd         (mem_rd),
        .wb_reg_write   (wb_reg_write),
        .wb_rd          (wb_rd),
        .fwd_a_sel      (fwd_a_sel),
        .fwd_b_sel      (fwd_b_sel),
        .load_use_stall (load_use_stall),
        .stall_cycles   (stall_cycles)
    );

    always #5 clk = ~clk;

    // Model of what the EX stage currently holds.
    bit        armed = 1'b0;
    bit        m_valid = 1'b0;
    bit        m_rw = 1'b0;
    bit        m_mr = 1'b0;
    int        m_rs_data = 0;
    int        m_rt_data = 0;
    int        m_rs = 0;
    int        m_rt = 0;
    int        m_rd = 0;
    int        m_cnt = 0;

    function automatic bit model_lu();
        return m_valid && m_mr && (m_rd != 0) && bus.id_valid &&
               ((m_rd == int'(bus.id_rs)) || (m_rd == int'(bus.id_rt)));
    endfunction

    function automatic int model_sel(input int src);
        if (!m_valid) return 0;
        if (mem_reg_write && (mem_rd != 0) && (int'(mem_rd) == src)) return 2;
        if (wb_reg_write && (wb_rd != 0) && (int'(wb_rd) == src)) return 1;
        return 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update on each rising edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            armed   <= 1'b1;
            m_valid <= 1'b0;
            m_rw    <= 1'b0;
            m_mr    <= 1'b0;
            m_cnt   <= 0;
        end else begin
            if (flush || (!stall && model_lu())) begin
                m_valid <= 1'b0;
                m_rw    <= 1'b0;
                m_mr    <= 1'b0;
            end else if (!stall) begin
                m_valid   <= bus.id_valid;
                m_rw      <= bus.id_reg_write;
                m_mr      <= bus.id_mem_read;
                m_rs_data <= int'(bus.id_rs_data);
                m_rt_data <= int'(bus.id_rt_data);
                m_rs      <= int'(bus.id_rs);
                m_rt      <= int'(bus.id_rt);
                m_rd      <= int'(bus.id_rd_dst);
            end
            if (model_lu()) m_cnt <= (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        end
    end

    // Compare every cycle on the falling edge, once reset has been applied.
    always @(negedge clk) begin
        if (armed) begin
            chk("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
            chk("ex_reg_write", 32'(bus.ex_reg_write), 32'(m_valid & m_rw));
            chk("ex_mem_read", 32'(bus.ex_mem_read), 32'(m_valid & m_mr));
            chk("fwd_a_sel", 32'(fwd_a_sel), 32'(model_sel(m_rs)));
            chk("fwd_b_sel", 32'(fwd_b_sel), 32'(model_sel(m_rt)));
            chk("load_use_stall", 32'(load_use_stall), 32'(model_lu()));
            chk("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
            if (m_valid) begin
                chk("ex_rs_data", bus.ex_rs_data, m_rs_data);
                chk("ex_rt_data", bus.ex_rt_data, m_rt_data);
                chk("ex_rs", 32'(bus.ex_rs), 32'(m_rs));
                chk("ex_rt", 32'(bus.ex_rt), 32'(m_rt));
                chk("ex_rd_dst", 32'(bus.ex_rd_dst), 32'(m_rd));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input bit v, input int rs_d, input int rt_d, input int rs, input int rt,
                          input int rd, input bit rw, input bit mr);
        bus.id_valid     = v;
        bus.id_rs_data   = rs_d;
        bus.id_rt_data   = rt_d;
        bus.id_rs        = REG_AW'(rs);
        bus.id_rt        = REG_AW'(rt);
        bus.id_rd_dst    = REG_AW'(rd);
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
    endtask

    initial begin
        int base;
        set_id(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0);

        // T1 reset with random ID inputs
        rst_n = 1'b0;
        set_id(1'b1, $urandom, $urandom, $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 31), 1'b1, 1'b1);
        step();
        step();
        chk("t1_ex_valid", 32'(bus.ex_valid), 0);
        chk("t1_ex_mem_read", 32'(bus.ex_mem_read), 0);
        chk("t1_stall_cycles", 32'(stall_cycles), 0);
        chk("t1_fwd_a", 32'(fwd_a_sel), 0);
        chk("t1_lu", 32'(load_use_stall), 0);
        rst_n = 1'b1;

        // T2 pass-through
        set_id(1'b1, 32'h1234_5678, 32'h0, 8, 0, 3, 1'b1, 1'b0);
        step();
        chk("t2_ex_rs_data", bus.ex_rs_data, 32'h1234_5678);
        chk("t2_ex_rs", 32'(bus.ex_rs), 8);
        chk("t2_ex_valid", 32'(bus.ex_valid), 1);
        chk("t2_fwd_a", 32'(fwd_a_sel), 0);

        // T3 forwarding priority and $0 exclusion
        set_id(1'b1, 32'h11, 32'h22, 9, 9, 3, 1'b1, 1'b0);
        step();
        set_id(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        mem_reg_write = 1'b1; mem_rd = 9; wb_reg_write = 1'b1; wb_rd = 9;
        #2;
        chk("t3_mem_a", 32'(fwd_a_sel), 2);
        chk("t3_mem_b", 32'(fwd_b_sel), 2);
        mem_reg_write = 1'b0;
        #2;
        chk("t3_wb_a", 32'(fwd_a_sel), 1);
        chk("t3_wb_b", 32'(fwd_b_sel), 1);
        step();
        // EX is now a bubble: selects must be 00 even with matching indices
        chk("t3_bubble_a", 32'(fwd_a_sel), 0);
        set_id(1'b1, 32'h11, 32'h22, 0, 0, 3, 1'b1, 1'b0);
        step();
        mem_reg_write = 1'b1; mem_rd = 0; wb_reg_write = 1'b1; wb_rd = 0;
        #2;
        chk("t3_zero_a", 32'(fwd_a_sel), 0);
        chk("t3_zero_b", 32'(fwd_b_sel), 0);
        mem_reg_write = 1'b0; wb_reg_write = 1'b0;

        // T4 load-use
        set_id(1'b1, 32'h100, 32'h200, 1, 2, 10, 1'b1, 1'b1);
        step();
        set_id(1'b1, 32'h300, 32'h400, 10, 4, 11, 1'b1, 1'b0);
        #2;
        chk("t4_lu_on", 32'(load_use_stall), 1);
        chk("t4_cnt0", 32'(stall_cycles), 0);
        step();
        chk("t4_bubble", 32'(bus.ex_valid), 0);
        chk("t4_lu_off", 32'(load_use_stall), 0);
        chk("t4_cnt1", 32'(stall_cycles), 1);
        step();
        chk("t4_captured_rs", 32'(bus.ex_rs), 10);
        set_id(1'b1, 32'h5, 32'h6, 1, 2, 0, 1'b1, 1'b1);
        step();
        set_id(1'b1, 32'h7, 32'h8, 0, 0, 4, 1'b1, 1'b0);
        #2;
        chk("t4_rd0_no_lu", 32'(load_use_stall), 0);
        step();

        // T5 flush+stall -> bubble; stall alone holds for 3 cycles
        set_id(1'b1, 32'hAAAA, 32'hBBBB, 4, 6, 7, 1'b1, 1'b0);
        step();
        flush = 1'b1; stall = 1'b1;
        step();
        chk("t5_flush_wins", 32'(bus.ex_valid), 0);
        flush = 1'b0; stall = 1'b0;
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, $urandom, $urandom, $urandom_range(0, 31), $urandom_range(0, 31),
                   $urandom_range(0, 31), 1'b0, 1'b0);
            step();
            chk("t5_hold_data", bus.ex_rs_data, 32'hAAAA);
            chk("t5_hold_rs", 32'(bus.ex_rs), 4);
            chk("t5_hold_rd", 32'(bus.ex_rd_dst), 7);
            chk("t5_hold_valid", 32'(bus.ex_valid), 1);
        end
        stall = 1'b0;

        // stall together with load-use: hold, counter still counts; then reset mid-stall
        set_id(1'b1, 32'h1, 32'h2, 1, 2, 12, 1'b1, 1'b1);
        step();
        set_id(1'b1, 32'h3, 32'h4, 12, 3, 13, 1'b0, 1'b0);
        stall = 1'b1;
        step();
        step();
        chk("t5_stall_lu_held", 32'(load_use_stall), 1);
        chk("t5_stall_cnt", 32'(stall_cycles), 3);
        rst_n = 1'b0;
        step();
        chk("t5_rst_valid", 32'(bus.ex_valid), 0);
        chk("t5_rst_lu", 32'(load_use_stall), 0);
        chk("t5_rst_cnt", 32'(stall_cycles), 0);
        rst_n = 1'b1;
        stall = 1'b0;

        // T6 saturation: 20 load-use events alternate with bubbles
        set_id(1'b1, 32'h9, 32'h9, 5, 0, 5, 1'b1, 1'b1);
        base = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (i == 29) begin
                chk("t6_cnt_mid", 32'(stall_cycles), 15);
                base = 1;
            end
        end
        chk("t6_sat", 32'(stall_cycles), 32'hF);
        chk("t6_sat_seen", 32'(base), 1);
        set_id(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        step();
        step();
        chk("t6_no_wrap", 32'(stall_cycles), 32'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
